// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter: byte + send request in,
// busy/done/error status out.
interface ps2_host_tx_if;
  logic [7:0] din;
  logic       send;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output din, send, input busy, done, error);
  modport slave  (input din, send, output busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain pads via pull-low enables.
// Pad-to-fall-strobe latency 6 clk; send is ignored while busy, the device paces the frame.
module ps2_host_tx #(
  parameter int CLKFREQ_KHZ  = 12000,
  parameter int INHIBIT_US   = 100,
  parameter int START_TMO_US = 15000,
  parameter int BIT_TMO_US   = 2000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2clk_in,
  input  logic          ps2dat_in,
  output logic          ps2clk_oe,
  output logic          ps2dat_oe
);

  localparam int INH_CYC   = CLKFREQ_KHZ * INHIBIT_US / 1000;
  localparam int START_CYC = (CLKFREQ_KHZ * START_TMO_US + 999) / 1000;
  localparam int BIT_CYC   = (CLKFREQ_KHZ * BIT_TMO_US + 999) / 1000;
  localparam int TW        = $clog2(START_CYC + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYC - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE, FAIL
  } state_t;

  logic [1:0] clk_sync, dat_sync;
  logic [2:0] clk_hist, dat_hist;
  logic       clk_filt, dat_filt, clk_filt_d;
  logic       fall;

  // Filtered level moves only when the current and three previous synced samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_hist   <= 3'b111;
      dat_hist   <= 3'b111;
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2clk_in};
      dat_sync   <= {dat_sync[0], ps2dat_in};
      clk_hist   <= {clk_hist[1:0], clk_sync[1]};
      dat_hist   <= {dat_hist[1:0], dat_sync[1]};
      if ({clk_sync[1], clk_hist} == 4'b1111)      clk_filt <= 1'b1;
      else if ({clk_sync[1], clk_hist} == 4'b0000) clk_filt <= 1'b0;
      if ({dat_sync[1], dat_hist} == 4'b1111)      dat_filt <= 1'b1;
      else if ({dat_sync[1], dat_hist} == 4'b0000) dat_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [8:0]    shift, shift_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic          clk_oe_q, clk_oe_n, dat_oe_q, dat_oe_n;
  logic          done_q, done_n, error_q, error_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      bitcnt   <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      bitcnt   <= bitcnt_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + TW'(1);
    shift_n  = shift;
    bitcnt_n = bitcnt;
    clk_oe_n = clk_oe_q;
    dat_oe_n = dat_oe_q;
    done_n   = 1'b0;
    error_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n    = '0;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (host.send) begin
          shift_n  = {~^host.din, host.din};
          bitcnt_n = '0;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        // Data goes low in the same cycle the clock is released: request-to-send.
        if (cnt == INH_LAST) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          cnt_n    = '0;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (fall) begin
          dat_oe_n = ~shift[0];
          bitcnt_n = 4'd1;
          cnt_n    = '0;
          state_n  = XFER;
        end else if (cnt == START_LAST) begin
          state_n = FAIL;
        end
      end
      XFER: begin
        if (fall) begin
          cnt_n = '0;
          if (bitcnt == 4'd9) begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end else begin
            shift_n  = shift >> 1;
            dat_oe_n = ~shift[1];
            bitcnt_n = bitcnt + 4'd1;
          end
        end else if (cnt == BIT_LAST) begin
          state_n = FAIL;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_n   = '0;
          state_n = dat_filt ? FAIL : WAIT_IDLE;
        end else if (cnt == BIT_LAST) begin
          state_n = FAIL;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && dat_filt) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == BIT_LAST) begin
          state_n = FAIL;
        end
      end
      FAIL: begin
        error_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == FAIL) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2dat_oe  = dat_oe_q;
  assign host.busy  = (state != IDLE);
  assign host.done  = done_q;
  assign host.error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 device; clock scaled to 1200 kHz
// so the timeouts stay short (inhibit 120, start timeout 18000, bit timeout 2400 cycles).
module tb_ps2_host_tx;
  localparam int KHZ   = 1200;
  localparam int INH   = 120;
  localparam int START = 18000;
  localparam int BITT  = 2400;
  localparam int HALF  = 40;

  logic clk = 1'b0;
  logic rst;
  logic ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe;
  logic dev_clk, dev_dat;

  ps2_host_tx_if hif();

  ps2_host_tx #(.CLKFREQ_KHZ(KHZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif.slave),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe)
  );

  assign ps2clk_in = dev_clk & ~ps2clk_oe;
  assign ps2dat_in = dev_dat & ~ps2dat_oe;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0, err_cnt = 0, both_bad = 0, busy_bad = 0;
  int inh_run = 0, inh_len = 0, t_rel = 0, t_err = 0;
  logic prev_clk_oe = 1'b0;
  logic dat_at_rel  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hif.done)  done_cnt <= done_cnt + 1;
    if (hif.error) begin
      err_cnt <= err_cnt + 1;
      t_err   <= cyc;
    end
    if (hif.done && hif.error) both_bad <= both_bad + 1;
    if ((hif.done || hif.error) && hif.busy) busy_bad <= busy_bad + 1;
    if (ps2clk_oe) begin
      inh_run <= inh_run + 1;
    end else begin
      if (prev_clk_oe) begin
        inh_len    <= inh_run;
        t_rel      <= cyc;
        dat_at_rel <= ps2dat_oe;
      end
      inh_run <= 0;
    end
    prev_clk_oe <= ps2clk_oe;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  typedef struct packed {
    logic [7:0]  din;
    logic [3:0]  nclk;
    logic        ack;
    logic        glitch;
    logic [10:0] frame;   // {stop, parity, d7..d0, start} as seen on the pad
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t tbl [0:6];

  task automatic do_send(input logic [7:0] d);
    @(negedge clk);
    hif.din  = d;
    hif.send = 1'b1;
    @(negedge clk);
    hif.send = 1'b0;
    hif.din  = 8'hA5;
  endtask

  task automatic run_dev(input int nclk, input bit ack, input bit glitch,
                         output logic [10:0] fr, output int tfall, output bit ok);
    fr = '0;
    tfall = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (ps2dat_oe && !ps2clk_oe) ok = 1'b1;
    end
    if (!ok) return;
    repeat (20) @(negedge clk);
    fr[0] = ps2dat_in;
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      tfall = cyc;
      repeat (HALF) @(negedge clk);
      if (k <= 10) fr[k] = ps2dat_in;
      dev_clk = 1'b1;
      if (k == 10 && ack) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      if (glitch && k == 3) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 12) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic wait_result(input int d0, input int e0, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0 || err_cnt != e0) seen = 1'b1;
    end
    check("result_seen", seen, 1'b1);
  endtask

  task automatic apply_row(input vec_t v, input bit mid);
    int d0, e0, tf;
    logic [10:0] fr;
    bit ok;
    bit busy_mid;
    d0 = done_cnt;
    e0 = err_cnt;
    busy_mid = 1'b1;
    do_send(v.din);
    check("busy_after_send", hif.busy, 1'b1);
    if (mid) begin
      fork
        run_dev(int'(v.nclk), v.ack, v.glitch, fr, tf, ok);
        begin
          repeat (400) @(negedge clk);
          busy_mid = hif.busy;
          hif.din  = 8'h00;
          hif.send = 1'b1;
          @(negedge clk);
          hif.send = 1'b0;
        end
      join
      check("busy_at_second_send", busy_mid, 1'b1);
    end else begin
      run_dev(int'(v.nclk), v.ack, v.glitch, fr, tf, ok);
    end
    check("rts_seen", ok, 1'b1);
    wait_result(d0, e0, 30000);
    repeat (10) @(negedge clk);
    check("inhibit_len", inh_len, INH);
    check("dat_low_at_clk_release", dat_at_rel, 1'b1);
    if (v.nclk == 4'd11) check("frame", fr, v.frame);
    check("done_pulses", done_cnt - d0, v.exp_done);
    check("error_pulses", err_cnt - e0, v.exp_err);
    check("busy_after", hif.busy, 1'b0);
    check("oe_after", {ps2clk_oe, ps2dat_oe}, 2'b00);
    if (v.nclk == 4'd0)  check_range("start_timeout", t_err - t_rel, START, START + 8);
    if (v.nclk == 4'd4)  check_range("bit_timeout", t_err - tf, BITT, BITT + 12);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, tf;
    logic [10:0] fr;
    bit ok;

    tbl[0] = '{din: 8'hF4, nclk: 4'd11, ack: 1'b1, glitch: 1'b0, frame: 11'h5E8, exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = '{din: 8'hED, nclk: 4'd11, ack: 1'b0, glitch: 1'b0, frame: 11'h7DA, exp_done: 1'b0, exp_err: 1'b1};
    tbl[2] = '{din: 8'h55, nclk: 4'd0,  ack: 1'b0, glitch: 1'b0, frame: 11'h000, exp_done: 1'b0, exp_err: 1'b1};
    tbl[3] = '{din: 8'hF4, nclk: 4'd4,  ack: 1'b0, glitch: 1'b0, frame: 11'h000, exp_done: 1'b0, exp_err: 1'b1};
    tbl[4] = '{din: 8'hF4, nclk: 4'd11, ack: 1'b1, glitch: 1'b1, frame: 11'h5E8, exp_done: 1'b1, exp_err: 1'b0};
    tbl[5] = '{din: 8'h00, nclk: 4'd11, ack: 1'b1, glitch: 1'b0, frame: 11'h600, exp_done: 1'b1, exp_err: 1'b0};
    tbl[6] = '{din: 8'hFF, nclk: 4'd11, ack: 1'b1, glitch: 1'b0, frame: 11'h7FE, exp_done: 1'b1, exp_err: 1'b0};

    rst = 1'b1;
    hif.send = 1'b0;
    hif.din  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy", hif.busy, 1'b0);
    check("rst_done", hif.done, 1'b0);
    check("rst_error", hif.error, 1'b0);
    check("rst_oe", {ps2clk_oe, ps2dat_oe}, 2'b00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) apply_row(tbl[i], 1'b0);

    // second send with a different byte while the first is in flight
    apply_row(tbl[0], 1'b1);

    // reset in the middle of the data phase
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hF4);
    run_dev(3, 1'b0, 1'b0, fr, tf, ok);
    check("rst_xfer_rts", ok, 1'b1);
    check("rst_xfer_busy_before", hif.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_xfer_oe", {ps2clk_oe, ps2dat_oe}, 2'b00);
    check("rst_xfer_busy", hif.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BITT + 200) @(negedge clk);
    check("rst_xfer_no_done", done_cnt - d0, 0);
    check("rst_xfer_no_error", err_cnt - e0, 0);
    apply_row(tbl[0], 1'b0);

    check("done_error_overlap", both_bad, 0);
    check("busy_during_pulse", busy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the counterpart of the PS/2 receivers already in the design: it sends one command byte to a keyboard or mouse, for example 0xF4 (mouse enable reporting) or 0xED followed by the LED byte. It drives the open-drain clock and data lines through pull-low enables and follows the standard inhibit / request-to-send / device-clocked / ACK sequence. The block sits beside ps2_mouse and ps2 on the shared inout pads. The top level builds each pad as `oe ? 1'b0 : 1'bz`.

Parameters:
CLKFREQ_KHZ, 12000, system clock frequency in kHz; all timing counts derive from it.
INHIBIT_US, 100, duration the host holds the clock line low before the request.
START_TMO_US, 15000, maximum wait from releasing the clock to the first device falling edge.
BIT_TMO_US, 2000, maximum wait between consecutive device falling edges.

Ports:
clk  in  1  system clock (12 MHz in the SAM build).
rst  in  1  synchronous, active-high reset.
din  in  8  byte to send; latched on an accepted send.
send  in  1  one-cycle request; accepted only when busy=0.
busy  out  1  high from the accepted send until the done/error cycle.
done  out  1  one-cycle pulse: byte sent and device ACK seen.
error  out  1  one-cycle pulse: timeout or missing ACK.
ps2clk_in  in  1  raw pad level of the PS/2 clock (asynchronous).
ps2dat_in  in  1  raw pad level of the PS/2 data (asynchronous).
ps2clk_oe  out  1  1 = pull the clock pad low.
ps2dat_oe  out  1  1 = pull the data pad low.

Behaviour:
- Reset: busy=0, done=0, error=0, ps2clk_oe=0, ps2dat_oe=0, state=IDLE, counters=0, filters preset to 1.
- Reset while a transfer is in progress releases both lines on the next edge. No done or error pulse is produced.
- Input conditioning:
  - Each pad goes through a 2-FF synchronizer, then a 4-sample filter.
  - The filtered level changes only when 4 consecutive synced samples agree.
  - fall = filtered clock goes 1→0, a one-cycle strobe.
  - Pad-to-strobe latency is 6 clk.
- Frame: start 0, data bits d0..d7 (LSB first), odd parity (ones in data+parity odd), stop 1 (host releases data), then a device ACK bit.
- IDLE: both oe=0.
  - send=1 → latch shift={parity,din}, bitcnt=0, busy=1, ps2clk_oe=1, go to INHIBIT.
- INHIBIT: ps2clk_oe=1 for exactly CLKFREQ_KHZ*INHIBIT_US/1000 cycles (1200 at defaults). Then ps2dat_oe=1, and ps2clk_oe=0 in the same cycle; go to REQ.
- REQ: wait for fall.
  - On the first fall, drive bit d0: ps2dat_oe = ~shift[0]. Go to XFER.
  - Timeout after START_TMO cycles (180000 at defaults) → FAIL.
- XFER: on each fall, shift right and drive the next bit.
  - Order: d1..d7, parity, then stop with ps2dat_oe=0.
  - After the stop bit is driven (10 falls total), go to ACK.
  - The timeout counter reloads on every fall. BIT_TMO (24000 cycles) without a fall → FAIL.
- ACK: on the 11th fall, sample the filtered data line.
  - 0 → WAIT_IDLE.
  - 1 → FAIL.
  - BIT_TMO without a fall → FAIL.
- WAIT_IDLE: wait until filtered clock=1 and data=1, then pulse done and go to IDLE.
  - BIT_TMO here → FAIL.
- FAIL: release both lines, pulse error, go to IDLE.
- busy falls in the same cycle that done or error pulses. done and error are never high together.
- send while busy=1 is ignored. din changes after acceptance have no effect.
- Data changes only on the fall strobe, i.e. while the device clock is low. The device samples on the rising edge.
- ps2clk_oe and ps2dat_oe are never both released during INHIBIT-to-REQ except as specified. The data line is pulled low before the clock is released, in the same cycle.
- Timeout counter width is 18 bits, sized by CLKFREQ_KHZ*START_TMO_US/1000 rounded up.

Test Plan:
- send din=0xF4, device model clocks at 12.5 kHz and ACKs → ps2clk_oe low for 1200 cycles; bits on data read 0,0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses once; error=0; busy low afterwards.
- send din=0xED, device does not pull data on the 11th clock → parity bit observed = 1; error pulses once, done never pulses.
- send 0x55, device never clocks → error exactly 180000 cycles (±filter latency) after ps2clk_oe falls; both oe=0 afterwards.
- Device stops clocking after bit d3 → error 24000 cycles after the 4th fall.
- Second send pulse with din=0x00 mid-transfer of 0xF4 → ignored; the transmitted byte stays 0xF4 and there is a single done pulse.
- Inject a 2-cycle low glitch on the device clock during XFER → no extra bit consumed; frame still correct; done pulses.
- Assert rst during XFER → both oe=0 the next cycle, busy=0, no done/error; a subsequent send of 0xF4 completes normally.
